// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative lookup cache: FSM states,
// default geometry and the address-field width helpers.
package cache_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOOKUP  = 2'd1,
      S_REFILL  = 2'd2,
      S_RESPOND = 2'd3
   } state_e;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_SETS   = 64;
   localparam int DEF_WAYS   = 2;

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   // Byte-offset bits [1:0] are never part of the tag.
   function automatic int tag_w(input int addr_w, input int sets);
      return addr_w - $clog2(sets) - 2;
   endfunction

   // A direct-mapped build still needs a 1-bit way index.
   function automatic int way_w(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// Request, response and refill signals of the cache grouped as one bundle.
interface set_assoc_cache_if
   import cache_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              flush;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_data;
   logic              resp_hit;
   logic              mem_rd_valid;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic              mem_rd_ack;
   logic [DATA_W-1:0] mem_rd_data;
   logic [31:0]       access_count;
   logic [31:0]       hit_count;

   modport slave (
      input  req_valid, req_addr, flush, mem_rd_ack, mem_rd_data,
      output req_ready, resp_valid, resp_data, resp_hit,
             mem_rd_valid, mem_rd_addr, access_count, hit_count
   );

   modport master (
      output req_valid, req_addr, flush, mem_rd_ack, mem_rd_data,
      input  req_ready, resp_valid, resp_data, resp_hit,
             mem_rd_valid, mem_rd_addr, access_count, hit_count
   );
endinterface

// File: rtl/cache_tag_cmp.sv
// Parallel tag compare across the ways of one set, with one-hot to binary
// way encode and a multi-hit flag for checking.
module cache_tag_cmp #(
   parameter int TAG_W = 24,
   parameter int WAYS  = 2,
   parameter int WAY_W = 1
) (
   input  logic [WAYS-1:0]            valid,
   input  logic [WAYS-1:0][TAG_W-1:0] way_tag,
   input  logic [TAG_W-1:0]           lookup_tag,
   output logic                       hit,
   output logic [WAY_W-1:0]           hit_way,
   output logic                       multi_hit
);
   logic [WAYS-1:0] hit_vec;

   // OR-ing the indices of set bits is an exact encode when one-hot.
   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         hit_vec[w] = valid[w] && (way_tag[w] == lookup_tag);
         if (hit_vec[w]) begin
            hit_way = hit_way | WAY_W'(w);
         end
      end
   end

   assign hit       = |hit_vec;
   assign multi_hit = (hit_vec & (hit_vec - WAYS'(1))) != '0;
endmodule

// File: rtl/set_assoc_cache.sv
// Read-only set-associative lookup cache, one word per line, with
// single-outstanding refill, whole-cache flush and saturating statistics.
//
// state     | meaning
// S_IDLE    | ready for a request; flush takes priority over a request
// S_LOOKUP  | tag compare on the latched address, count the access
// S_REFILL  | refill request held until mem_rd_ack, then fill victim
// S_RESPOND | single-cycle response pulse
module set_assoc_cache
   import cache_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int SETS   = DEF_SETS,
   parameter int WAYS   = DEF_WAYS
) (
   input logic               clk,
   input logic               rst,
   set_assoc_cache_if.slave  bus
);
   localparam int IDX_W = idx_w(SETS);
   localparam int TAG_W = tag_w(ADDR_W, SETS);
   localparam int WAY_W = way_w(WAYS);

   state_e                      state_q, state_d;
   logic [ADDR_W-1:2]           addr_q, addr_d;
   logic [DATA_W-1:0]           resp_data_q, resp_data_d;
   logic                        resp_hit_q, resp_hit_d;
   logic [31:0]                 access_q, access_d;
   logic [31:0]                 hits_q, hits_d;
   logic [SETS-1:0][WAYS-1:0]   valid_q, valid_d;
   logic [SETS-1:0][WAY_W-1:0]  rr_q, rr_d;

   logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
   logic [DATA_W-1:0] data_mem [SETS][WAYS];

   logic [IDX_W-1:0]            idx;
   logic [TAG_W-1:0]            tag;
   logic [WAYS-1:0][TAG_W-1:0]  set_tags;
   logic                        hit;
   logic [WAY_W-1:0]            hit_way;
   logic                        multi_hit;
   logic [WAY_W-1:0]            victim;
   logic                        all_valid;
   logic                        fill_en;

   assign idx       = addr_q[IDX_W+1:2];
   assign tag       = addr_q[ADDR_W-1:IDX_W+2];
   assign all_valid = &valid_q[idx];

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         set_tags[w] = tag_mem[idx][w];
      end
   end

   cache_tag_cmp #(
      .TAG_W (TAG_W),
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_tag_cmp (
      .valid      (valid_q[idx]),
      .way_tag    (set_tags),
      .lookup_tag (tag),
      .hit        (hit),
      .hit_way    (hit_way),
      .multi_hit  (multi_hit)
   );

   // Descending scan so the lowest invalid way is the last one written.
   always_comb begin
      victim = rr_q[idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[idx][w]) begin
            victim = WAY_W'(w);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      resp_data_d = resp_data_q;
      resp_hit_d  = resp_hit_q;
      access_d    = access_q;
      hits_d      = hits_q;
      valid_d     = valid_q;
      rr_d        = rr_q;
      fill_en     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.flush) begin
               valid_d = '0;
               rr_d    = '0;
            end else if (bus.req_valid) begin
               addr_d  = bus.req_addr[ADDR_W-1:2];
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            access_d = sat_inc(access_q);
            if (hit) begin
               hits_d      = sat_inc(hits_q);
               resp_hit_d  = 1'b1;
               resp_data_d = data_mem[idx][hit_way];
               state_d     = S_RESPOND;
            end else begin
               state_d = S_REFILL;
            end
         end
         S_REFILL: begin
            if (bus.mem_rd_ack) begin
               fill_en                = 1'b1;
               valid_d[idx][victim]   = 1'b1;
               if (all_valid) begin
                  rr_d[idx] = (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0
                                                              : rr_q[idx] + WAY_W'(1);
               end
               resp_hit_d  = 1'b0;
               resp_data_d = bus.mem_rd_data;
               state_d     = S_RESPOND;
            end
         end
         S_RESPOND: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         resp_data_q <= '0;
         resp_hit_q  <= 1'b0;
         access_q    <= '0;
         hits_q      <= '0;
         valid_q     <= '0;
         rr_q        <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         resp_data_q <= resp_data_d;
         resp_hit_q  <= resp_hit_d;
         access_q    <= access_d;
         hits_q      <= hits_d;
         valid_q     <= valid_d;
         rr_q        <= rr_d;
      end
   end

   // Line storage is qualified by valid_q, so it carries no reset.
   always_ff @(posedge clk) begin
      if (!rst && fill_en) begin
         tag_mem[idx][victim]  <= tag;
         data_mem[idx][victim] <= bus.mem_rd_data;
      end
   end

   // Outputs are forced quiet combinationally while rst is held.
   assign bus.req_ready    = !rst && (state_q == S_IDLE) && !bus.flush;
   assign bus.resp_valid   = !rst && (state_q == S_RESPOND);
   assign bus.resp_hit     = bus.resp_valid && resp_hit_q;
   assign bus.resp_data    = bus.resp_valid ? resp_data_q : '0;
   assign bus.mem_rd_valid = !rst && (state_q == S_REFILL);
   assign bus.mem_rd_addr  = bus.mem_rd_valid ? {addr_q, 2'b00} : '0;
   assign bus.access_count = rst ? 32'd0 : access_q;
   assign bus.hit_count    = rst ? 32'd0 : hits_q;

   a_single_hit : assert property (@(posedge clk) disable iff (rst)
      (state_q == S_LOOKUP) |-> !multi_hit);

endmodule
